instr_decode_issue: RTL and testbench
=====================================

# instr_decode_issue

Decode-and-issue stage between the fetch unit and the register file / ALU in the 10-bit CPU. It accepts one 10-bit instruction per cycle over a valid/ready handshake and registers the decoded fields into a single issue register. From there it drives the register-file read/write addresses, `alu_ctrl` and `we`. A write-back scoreboard stalls read-after-write hazards, `flush` cancels in-flight work on a taken branch, and a HALT opcode stops the stage until reset.

## Interface
- `WB_LATENCY`, default 1: cycles after the issue cycle until a write is visible to register-file reads. Legal range 0..3.
- `clk` in 1: global clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1: fetch presents `instr`.
- `instr` in 10: instruction word. Fields are `op[9:7]`, `rd[6:4]`, `rs[3:1]`; bit 0 is ignored.
- `flush` in 1: taken branch. Cancels the issue register and discards the presented instruction.
- `instr_ready` out 1: stage accepts `instr` this cycle.
- `iss_valid` out 1: decoded instruction issues this cycle.
- `raddr1` out 3: `rd`, the first operand.
- `raddr2` out 3: `rs`, the second operand.
- `waddr` out 3: `rd`, the destination.
- `alu_ctrl` out 3: `op`.
- `we` out 1: register-file write enable.
- `halted` out 1: sticky halt flag.

## Operation
- Semantics: R[rd] = R[rd] op R[rs]. Op 3'b000 is ADD. Op 3'b111 is HALT: no operands, no write.
- Accept happens when `instr_valid & instr_ready`. The decoded fields load into the issue register, and `iss_q` is set.
- `instr_ready = !halted & !halt_pending & (flush | !hazard)`.
  - `halt_pending` is `iss_q` holding HALT.
  - `hazard` is true when `rd` or `rs` matches any member of the busy set.
  - HALT never raises `hazard`.
- Busy set:
  - the issue-register destination, if `iss_q` is set and the op is not HALT;
  - each valid scoreboard entry `sb[0..WB_LATENCY-1]`.
- Scoreboard shift at every edge:
  - `sb[0]` loads the issue-register destination, valid only if the stage issued a writing instruction unflushed;
  - `sb[k]` loads `sb[k-1]`.
  - With `WB_LATENCY=0` the scoreboard is empty.
- Outputs (combinational from the issue register and `flush`):
  - `iss_valid = iss_q & !flush`;
  - `we = iss_valid & (op != HALT)`.
  - Address and ctrl fields hold their last decoded value while not valid.
- Flush cycle:
  - the issue register does not issue and is not pushed to `sb[0]`;
  - a presented instruction is consumed (`instr_ready=1` if not halted/halt_pending) and discarded;
  - `iss_q` clears at the edge;
  - scoreboard entries already in `sb` are kept, because those writes have already executed.
- States: RUN → HALT_PENDING → HALTED.
  - RUN → HALT_PENDING: HALT accepted.
  - HALT_PENDING → HALTED: the HALT issues unflushed. `halted` is set at the end of its issue cycle.
  - HALT_PENDING → RUN: the HALT is flushed.
  - HALTED is exited only by reset. `flush` has no effect on HALTED.
- Simultaneous accept and issue: at one edge the new instruction replaces the issue register while the old destination moves to `sb[0]`.

## Timing
- Reset (asynchronous, immediate): `iss_q`, all `sb` entries, `halted` and all field registers are 0.
  - Outputs: `iss_valid=0`, `we=0`, `raddr1/raddr2/waddr/alu_ctrl=0`, `halted=0`.
  - `instr_ready=1` once reset deasserts.
- Issue latency: an instruction accepted at edge E issues during cycle (E, E+1).
- Independent instructions sustain one per cycle.
- Dependent instruction (RAW through rd or rs), with the producer accepted at edge E0 and no flush:
  - accepted at edge E0+WB_LATENCY+2;
  - `instr_ready` is low for WB_LATENCY+1 cycles.
- Reset mid-stall or mid-HALT discards all state; nothing issues after reset.

## Structure
- Package `cpu_pkg` holds:
  - `DATA_W=10`, `REG_AW=3`;
  - field bit positions;
  - opcode constants `OP_ADD=3'b000`, `OP_HALT=3'b111`.
- One sub-module, `issue_scoreboard`: the `WB_LATENCY`-deep shift register of (valid, dest) entries, with two 3-bit match ports returning the busy hit.

## Test plan
- Reset test: assert `reset` with `instr_valid=1`.
  - During reset: all outputs 0.
  - After release: `instr_ready=1`, and the first instruction issues one cycle after acceptance.
- ADD issue: present 10'h032 (ADD r3,r1).
  - Next cycle: `iss_valid=1`, `raddr1=3`, `raddr2=1`, `waddr=3`, `alu_ctrl=0`, `we=1`.
- Independent back-to-back: 10'h032 then 10'h04A (ADD r4,r5), `WB_LATENCY=1`.
  - Both accepted on consecutive edges; `iss_valid` stays high for 2 cycles.
- RAW stall: 10'h032 accepted at E0, then 10'h0B6 (op1 r3,r3), `WB_LATENCY=1`.
  - `instr_ready` low for 2 cycles; accepted at E3.
  - Repeat with `WB_LATENCY=3`: accepted at E5.
- Flush: assert `flush` during the issue cycle of 10'h032 while 10'h0B6 is presented.
  - That cycle: `iss_valid=0`, `we=0`, 10'h0B6 discarded.
  - Next: 10'h0B6 accepted at the following edge with no stall.
- HALT: present 10'h380.
  - Issue cycle: `iss_valid=1`, `alu_ctrl=7`, `we=0`; `halted=1` from the next cycle.
  - Afterwards: `instr_ready` stays 0 for 20 cycles of `instr_valid=1`.
  - Asynchronous `reset` clears `halted` immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths, instruction field positions and opcodes for the
//           10-bit CPU.
// Rev     : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 10;
  localparam int REG_AW = 3;
  localparam int OP_W   = 3;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 7;
  localparam int RD_MSB = 6;
  localparam int RD_LSB = 4;
  localparam int RS_MSB = 3;
  localparam int RS_LSB = 1;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
  } decoded_t;

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : issue_scoreboard
// Brief   : WB_LATENCY-deep shift register of in-flight register writes with
//           two destination match ports.
// Rev     : 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import cpu_pkg::*;
#(
  parameter int WB_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_dest,
  input  logic [REG_AW-1:0] match_a,
  input  logic [REG_AW-1:0] match_b,
  output logic              hit_a,
  output logic              hit_b
);

  generate
    if (WB_LATENCY == 0) begin : g_empty
      logic w_unused;
      assign w_unused = ^{clk, reset, push_valid, push_dest, match_a, match_b};
      assign hit_a    = 1'b0;
      assign hit_b    = 1'b0;
    end else begin : g_shift
      logic [WB_LATENCY-1:0] r_valid;
      logic [REG_AW-1:0]     r_dest [WB_LATENCY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid <= '0;
          for (int k = 0; k < WB_LATENCY; k++) r_dest[k] <= '0;
        end else begin
          r_valid[0] <= push_valid;
          r_dest[0]  <= push_dest;
          for (int k = 1; k < WB_LATENCY; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_dest[k]  <= r_dest[k-1];
          end
        end
      end

      always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int k = 0; k < WB_LATENCY; k++) begin
          hit_a = hit_a | (r_valid[k] & (r_dest[k] == match_a));
          hit_b = hit_b | (r_valid[k] & (r_dest[k] == match_b));
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_decode_issue.sv
`default_nettype none
// ============================================================================
// Module  : instr_decode_issue
// Brief   : Decode-and-issue stage with RAW scoreboard, branch flush and HALT.
// Rev     : 1.0 - initial release
// ============================================================================
module instr_decode_issue
  import cpu_pkg::*;
#(
  parameter int WB_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  input  logic              flush,
  output logic              instr_ready,
  output logic              iss_valid,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [REG_AW-1:0] waddr,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic              we,
  output logic              halted
);

  localparam logic [1:0] c_st_run          = 2'd0;
  localparam logic [1:0] c_st_halt_pending = 2'd1;
  localparam logic [1:0] c_st_halted       = 2'd2;

  logic [1:0] r_state;
  logic       r_iss_q;
  decoded_t   r_iss;

  decoded_t w_dec;
  logic     w_unused;
  logic     w_issue_busy;
  logic     w_sb_hit_rd;
  logic     w_sb_hit_rs;
  logic     w_hazard;
  logic     w_load;

  assign w_dec.op = instr[OP_MSB:OP_LSB];
  assign w_dec.rd = instr[RD_MSB:RD_LSB];
  assign w_dec.rs = instr[RS_MSB:RS_LSB];
  assign w_unused = instr[0];

  assign w_issue_busy = r_iss_q & (r_iss.op != OP_HALT);

  // HALT reads and writes nothing, so it never waits on a pending write.
  assign w_hazard = (w_dec.op != OP_HALT) &
                    (w_sb_hit_rd | w_sb_hit_rs |
                     (w_issue_busy & ((r_iss.rd == w_dec.rd) | (r_iss.rd == w_dec.rs))));

  assign instr_ready = (r_state == c_st_run) & (flush | !w_hazard);
  assign w_load      = instr_valid & instr_ready & !flush;

  assign iss_valid = r_iss_q & !flush;
  assign we        = iss_valid & (r_iss.op != OP_HALT);
  assign raddr1    = r_iss.rd;
  assign raddr2    = r_iss.rs;
  assign waddr     = r_iss.rd;
  assign alu_ctrl  = r_iss.op;
  assign halted    = (r_state == c_st_halted);

  issue_scoreboard #(
    .WB_LATENCY (WB_LATENCY)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .push_valid (we),
    .push_dest  (r_iss.rd),
    .match_a    (w_dec.rd),
    .match_b    (w_dec.rs),
    .hit_a      (w_sb_hit_rd),
    .hit_b      (w_sb_hit_rs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_run;
      r_iss_q <= 1'b0;
      r_iss   <= '0;
    end else begin
      r_iss_q <= w_load;
      if (w_load) r_iss <= w_dec;
      case (r_state)
        c_st_run:          if (w_load && (w_dec.op == OP_HALT)) r_state <= c_st_halt_pending;
        c_st_halt_pending: r_state <= flush ? c_st_run : c_st_halted;
        default:           r_state <= r_state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_decode_issue
// Brief   : Scoreboard bench for instr_decode_issue (WB_LATENCY 1 and 3).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instr_decode_issue;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [9:0] instr;
  logic       flush;
  logic       instr_ready, iss_valid, we, halted;
  logic [2:0] raddr1, raddr2, waddr, alu_ctrl;

  logic       v3, flush3;
  logic [9:0] i3;
  logic       ready3, iss3, we3, halted3;
  logic [2:0] ra1_3, ra2_3, wa3, alu3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  decoded_t exp_q[$];
  decoded_t mon_e;
  decoded_t drop;

  instr_decode_issue #(.WB_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .instr_ready(instr_ready), .iss_valid(iss_valid), .raddr1(raddr1), .raddr2(raddr2),
    .waddr(waddr), .alu_ctrl(alu_ctrl), .we(we), .halted(halted)
  );

  instr_decode_issue #(.WB_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .instr_valid(v3), .instr(i3), .flush(flush3),
    .instr_ready(ready3), .iss_valid(iss3), .raddr1(ra1_3), .raddr2(ra2_3),
    .waddr(wa3), .alu_ctrl(alu3), .we(we3), .halted(halted3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue of the WB_LATENCY=1 instance is matched against the queue.
  always @(negedge clk) begin
    if (!reset && iss_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue: unexpected iss_valid ctrl=%0d waddr=%0d", alu_ctrl, waddr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({raddr1, raddr2, waddr, alu_ctrl, we} !==
            {mon_e.rd, mon_e.rs, mon_e.rd, mon_e.op, (mon_e.op != OP_HALT)}) begin
          fails++;
          $display("FAIL issue: got ra1=%0d ra2=%0d wa=%0d ctrl=%0d we=%0d, expected ra1=%0d ra2=%0d wa=%0d ctrl=%0d we=%0d",
                   raddr1, raddr2, waddr, alu_ctrl, we,
                   mon_e.rd, mon_e.rs, mon_e.rd, mon_e.op, (mon_e.op != OP_HALT));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents w until accepted; returns the acceptance cycle and stall count.
  task automatic send(input logic [9:0] w, output int acc, output int stalls);
    decoded_t d;
    instr_valid = 1'b1;
    instr       = w;
    stalls      = 0;
    acc         = -1;
    while (acc < 0) begin
      @(negedge clk);
      if (instr_ready) begin
        if (!flush) begin
          d.op = w[9:7];
          d.rd = w[6:4];
          d.rs = w[3:1];
          exp_q.push_back(d);
        end
        acc = cyc;
      end else if (stalls >= 20) begin
        tests++;
        fails++;
        $display("FAIL send timeout: instr %h not accepted after %0d cycles", w, stalls);
        acc = cyc;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, n0, n1, b0, b1, n;
    logic [9:0] consumers [3];
    consumers[0] = 10'h0B6;
    consumers[1] = 10'h056;
    consumers[2] = 10'h030;

    reset = 1'b1; instr_valid = 1'b1; instr = 10'h032; flush = 1'b0;
    v3 = 1'b0; i3 = '0; flush3 = 1'b0;

    // Reset with a valid instruction presented
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset iss_valid", iss_valid, 0);
    check("reset we", we, 0);
    check("reset fields", {raddr1, raddr2, waddr, alu_ctrl}, 0);
    check("reset halted", halted, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("ready after reset", instr_ready, 1);
    send(10'h032, a0, n0);
    @(negedge clk);
    check("first issue latency", iss_valid, 1);

    // Independent back-to-back
    idle(4);
    send(10'h032, a0, n0);
    send(10'h04A, a1, n1);
    check("b2b accept gap", a1 - a0, 1);
    check("b2b stall", n1, 0);

    // RAW through rd+rs, rs only, rd only
    for (int k = 0; k < 3; k++) begin
      idle(4);
      send(10'h032, a0, n0);
      send(consumers[k], a1, n1);
      check("raw stall cycles", n1, 2);
      check("raw accept edge", a1 - a0, 3);
    end

    // RAW with WB_LATENCY=3
    idle(2);
    v3 = 1'b1; i3 = 10'h032;
    @(negedge clk);
    check("wb3 ready idle", ready3, 1);
    b0 = cyc;
    @(posedge clk); #1;
    i3 = 10'h0B6;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready3 || n >= 20) break;
      n++;
      @(posedge clk); #1;
    end
    b1 = cyc;
    @(posedge clk); #1;
    v3 = 1'b0;
    check("wb3 stall cycles", n, 4);
    check("wb3 accept edge", b1 - b0, 5);
    @(negedge clk);
    check("wb3 issue", {iss3, ra1_3, ra2_3, alu3, we3}, {1'b1, 3'd3, 3'd3, 3'd1, 1'b1});

    // Flush during issue of 032 with 0B6 presented
    idle(4);
    send(10'h032, a0, n0);
    flush = 1'b1; instr_valid = 1'b1; instr = 10'h0B6;
    drop = exp_q.pop_back();
    @(negedge clk);
    check("flush iss_valid", iss_valid, 0);
    check("flush we", we, 0);
    check("flush ready", instr_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    send(10'h0B6, a1, n1);
    check("post-flush stall", n1, 0);

    // Flushed HALT returns to RUN
    idle(4);
    send(10'h380, a0, n0);
    flush = 1'b1;
    drop = exp_q.pop_back();
    @(negedge clk);
    check("halt pending ready", instr_ready, 0);
    check("halt flush iss_valid", iss_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("halt flushed halted", halted, 0);
    check("halt flushed ready", instr_ready, 1);

    // HALT right after a write to r0: no hazard, then sticky halt
    idle(4);
    send({OP_ADD, 7'h00}, a0, n0);
    send(10'h380, a1, n1);
    check("halt no hazard", n1, 0);
    @(negedge clk);
    check("halt issue ctrl", alu_ctrl, 7);
    check("halt issue we", we, 0);
    check("halted in issue cycle", halted, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("halted after issue", halted, 1);
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = 10'h032;
    for (int i = 0; i < 20; i++) begin
      flush = (i % 3 == 0);
      @(negedge clk);
      check("halted ready", instr_ready, 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("halted sticky", halted, 1);

    // Asynchronous reset clears halt mid-cycle
    #2;
    reset = 1'b1;
    instr_valid = 1'b0;
    #1;
    check("async reset halted", halted, 0);
    check("async reset iss_valid", iss_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("ready after halt reset", instr_ready, 1);
    idle(3);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending issues: got %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
